// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB4 wait-state completer.
// Localparams describe the default 32-bit, 64-word configuration.
package apb_slv_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int STRB_W = 32 / 8;
  localparam int IDX_W  = $clog2(64);
  localparam int OFS_W  = $clog2(STRB_W);

  function automatic logic in_range(
    input logic [31:0] idx,
    input int unsigned depth
  );
    return idx < depth;
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// Word-organised storage with per-byte write strobes.
// Asynchronous read port; every word clears on reset.
module apb_slv_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6,
  parameter int STRB_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     strb_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = (int'(idx_i) < DEPTH) ? mem_q[idx_i] : '0;

endmodule

// File: rtl/apb4_wait_slave.sv
// APB4 completer: byte-strobed register file with programmable
// wait states and PSLVERR on out-of-range word index.
module apb4_wait_slave
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int WS_WIDTH   = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [WS_WIDTH-1:0]     wait_cfg,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e            state_q, state_d;
  logic [WS_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  slverr_q, slverr_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           idx;
  logic                  err;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  // Setup cycle decodes the live bus; access cycles use latched values.
  assign cur_addr = (state_q == IDLE) ? PADDR : addr_q;
  assign idx      = 32'(cur_addr) >> OW;
  assign err      = !in_range(idx, DEPTH);

  apb_slv_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IW),
    .STRB_W     (SW)
  ) u_regfile (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .we_i    (we),
    .idx_i   (idx[IW-1:0]),
    .wdata_i (wdata_q),
    .strb_i  (strb_q),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    pready_d = 1'b0;
    prdata_d = '0;
    slverr_d = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = wait_cfg;
          if (wait_cfg == '0) begin
            pready_d = 1'b1;
            slverr_d = err;
            prdata_d = (err || PWRITE) ? '0 : rdata;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pready_q) begin
          if (PENABLE) begin
            we      = wr_q && !err;
            state_d = IDLE;
          end else begin
            pready_d = 1'b1;
            slverr_d = slverr_q;
            prdata_d = prdata_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == WS_WIDTH'(1)) begin
            pready_d = 1'b1;
            slverr_d = err;
            prdata_d = (err || wr_q) ? '0 : rdata;
          end
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      slverr_q <= slverr_d;
    end
  end

  assign PREADY  = pready_q;
  assign PRDATA  = prdata_q;
  assign PSLVERR = slverr_q;

endmodule

// File: tb/tb_apb4_wait_slave.sv
// Scoreboard bench for apb4_wait_slave: driver queues expectations
// from a word-array model, a monitor checks each completion.
module tb_apb4_wait_slave;

  logic        clk = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [3:0]  wait_cfg;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  apb4_wait_slave #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .DEPTH      (64),
    .WS_WIDTH   (4)
  ) dut (
    .PCLK     (clk),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .wait_cfg (wait_cfg),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        err;
    int          ws;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [64];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // Monitor: counts access cycles and checks each completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!PRESETn || !PSEL || !PENABLE) begin
        acc = 0;
      end else begin
        acc++;
        if (PREADY) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_completion: got PREADY=1 expected none");
          end else begin
            e = q.pop_front();
            chk("access_cycles", 32'(acc), 32'(e.ws + 1));
            chk("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
            if (e.rd) chk("prdata", PRDATA, e.rdata);
          end
          acc = 0;
        end
      end
    end
  end

  task automatic setup(input logic wr, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input int ws);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = a; PWDATA = d; PSTRB = s; wait_cfg = 4'(ws);
  endtask

  // Access phase scrambles address/data/wait_cfg: only latched values count.
  task automatic enable();
    @(posedge clk); #1;
    PENABLE = 1'b1; wait_cfg = 4'd0;
    PADDR = 10'($urandom); PWDATA = $urandom; PSTRB = 4'($urandom);
  endtask

  function automatic exp_t mk_exp(input logic wr, input logic [9:0] a,
                                  input int ws);
    exp_t e;
    int   i;
    i = int'(a >> 2);
    e.rd = !wr; e.err = (i >= 64); e.ws = ws; e.rdata = '0;
    if (!wr && !e.err) e.rdata = model[i];
    return e;
  endfunction

  task automatic xfer(input logic wr, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int ws, output int done);
    exp_t e;
    bit   ok;
    int   i;
    e = mk_exp(wr, a, ws);
    q.push_back(e);
    setup(wr, a, d, s, ws);
    enable();
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (PREADY) begin ok = 1; break; end
    end
    done = cyc;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL timeout: got no PREADY expected PREADY at %0d", ws + 1);
      void'(q.pop_back());
    end else if (wr && !e.err) begin
      i = int'(a >> 2);
      for (int b = 0; b < 4; b++)
        if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  initial begin
    int t, tp;
    int ws;
    logic wr;
    logic [9:0] a;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; wait_cfg = '0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("reset_pready", {31'd0, PREADY}, 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
    @(posedge clk); #1; PRESETn = 1'b1;
    idle(1);

    xfer(1, 10'h010, 32'hDEADBEEF, 4'hF, 0, t);
    xfer(0, 10'h010, 32'h0, 4'h0, 0, t);
    idle(1);
    xfer(1, 10'h004, 32'h12345678, 4'hF, 3, t);
    xfer(0, 10'h004, 32'h0, 4'h0, 2, t);
    idle(2);
    xfer(1, 10'h008, 32'hAABBCCDD, 4'hF, 0, t);
    xfer(1, 10'h008, 32'h11223344, 4'b0101, 1, t);
    xfer(0, 10'h008, 32'h0, 4'h0, 0, t);
    xfer(1, 10'h00C, 32'h99999999, 4'h0, 0, t);
    xfer(0, 10'h00C, 32'h0, 4'h0, 0, t);
    idle(1);
    xfer(0, 10'h100, 32'h0, 4'h0, 2, t);
    xfer(1, 10'h100, 32'hFFFFFFFF, 4'hF, 1, t);
    xfer(1, 10'h0FC, 32'hCAFE0001, 4'hF, 0, t);
    xfer(0, 10'h0FC, 32'h0, 4'h0, 0, t);
    xfer(0, 10'h000, 32'h0, 4'h0, 0, t);
    idle(1);

    // Back-to-back: each transfer exactly two cycles apart.
    for (int k = 0; k < 8; k++) begin
      wr = (k < 4);
      xfer(wr, 10'(4 * (k % 4)), 32'(k % 4 + 1), 4'hF, 0, t);
      if (k > 0) chk("b2b_spacing", 32'(t - tp), 32'd2);
      tp = t;
    end
    idle(1);

    // PSEL dropped mid-wait: no commit, next transfer starts cleanly.
    q.push_back(mk_exp(1, 10'h024, 3));
    setup(1, 10'h024, 32'h5A5A5A5A, 4'hF, 3);
    enable();
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("abort_pready", {31'd0, PREADY}, 32'd0);
    xfer(0, 10'h024, 32'h0, 4'h0, 0, t);
    idle(1);

    // Reset during wait state of a write to 0x20.
    xfer(1, 10'h020, 32'h00000055, 4'hF, 0, t);
    q.push_back(mk_exp(1, 10'h020, 4));
    setup(1, 10'h020, 32'hCAFEF00D, 4'hF, 4);
    enable();
    @(posedge clk); #1;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    void'(q.pop_back());
    clear_model();
    #1 chk("rst_wait_pready", {31'd0, PREADY}, 32'd0);
    @(posedge clk); #1; PRESETn = 1'b1;
    xfer(0, 10'h020, 32'h0, 4'h0, 1, t);
    xfer(0, 10'h010, 32'h0, 4'h0, 0, t);

    // Reset asserted while PREADY is high clears outputs at once.
    xfer(1, 10'h030, 32'h77665544, 4'hF, 0, t);
    q.push_back(mk_exp(0, 10'h030, 2));
    setup(0, 10'h030, 32'h0, 4'h0, 2);
    enable();
    for (int k = 0; k < 16 && !PREADY; k++) @(negedge clk);
    #1 PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    chk("rst_rdy_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_rdy_prdata", PRDATA, 32'd0);
    clear_model();
    @(posedge clk); #1; PRESETn = 1'b1;
    xfer(0, 10'h030, 32'h0, 4'h0, 0, t);
    idle(1);

    for (int k = 0; k < 80; k++) begin
      wr = 1'($urandom);
      a  = 10'($urandom_range(0, 16'h10F));
      ws = $urandom_range(0, 3);
      xfer(wr, a, $urandom, 4'($urandom), ws, t);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    @(negedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL leftover: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
